lfsr_arbiter: RTL and testbench
===============================

LFSR_ARBITER -- requirements
Module: lfsr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter BURST, default 4: beats delivered per grant, range 1..16.
REQ-003 Parameter DEFAULT_SEED, default 8'h8A: LFSR state after reset and substitute for an all-zero seed.
REQ-004 Port clk, input, 1: one clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: reset is synchronous and active-high.
REQ-006 Port req, input, NREQ: level request per requester, held until the burst ends or the requester withdraws.
REQ-007 Port gnt, output, NREQ: one-hot owner of the current burst; zero when IDLE.
REQ-008 Port data, output, 8: current LFSR state, meaningful when valid=1.
REQ-009 Port valid, output, 1: a beat is delivered to the gnt owner this cycle.
REQ-010 Port last, output, 1: the current valid beat is the final beat of the burst.
REQ-011 Port seed_valid, input, 1: reseed request.
REQ-012 Port seed, input, 8: new LFSR state.
REQ-013 Port seed_ready, output, 1: high exactly when the FSM is in IDLE.

Function
REQ-014 The LFSR step SHALL be next = {s[6:0], s[0]^s[3]^s[5]^s[6]}.
REQ-015 The LFSR SHALL advance only on edges where valid=1; otherwise it holds.
REQ-016 The FSM SHALL have exactly two states, IDLE and BURST.
REQ-017 IDLE with seed_valid=1: the next edge SHALL load seed (DEFAULT_SEED if seed==0), stay in IDLE, and grant nothing; seed takes priority over arbitration.
REQ-018 IDLE with seed_valid=0 and any req bit set: the next edge SHALL register a one-hot gnt, clear the beat counter, and enter BURST.
REQ-019 Arbitration SHALL be round-robin: search starts at index (last owner+1) mod NREQ; after reset the search starts at index 0.
REQ-020 In BURST, valid SHALL equal req[owner] combinationally; data SHALL equal the LFSR state.
REQ-021 last SHALL be 1 when valid=1 and the beat count equals BURST-1.
REQ-022 An edge with valid=1 and last=1 SHALL return the FSM to IDLE, clear gnt, and advance the LFSR.
REQ-023 An edge in BURST with req[owner]=0 SHALL abort: return to IDLE, clear gnt, no LFSR advance, last owner still updated.
REQ-024 seed_valid in BURST SHALL be ignored; the seed is not queued.
REQ-025 Request changes by non-owners during BURST SHALL have no effect until IDLE.
REQ-026 Minimum grant-to-grant gap SHALL be one IDLE cycle; back-to-back requesters see one dead cycle between bursts.

Reset
REQ-027 On reset=1 at an edge, the block SHALL set: state IDLE, LFSR DEFAULT_SEED, gnt 0, beat count 0, round-robin pointer so that index 0 is highest priority.
REQ-028 During that cycle the outputs SHALL be valid=0, last=0, seed_ready=1.
REQ-029 Reset SHALL override every other input, including mid-burst.

Structure
REQ-030 A shared package SHALL hold DEFAULT_SEED, the tap positions, and the state enum {IDLE, BURST}.
REQ-031 The LFSR register and step function SHALL be one sub-module, lfsr_core, with ports clk, reset, load, load_value, advance and state.
REQ-032 The arbiter FSM and round-robin logic SHALL live in lfsr_arbiter.

Verification
REQ-033 Reset, then req=4'b0001 held: gnt=0001 from the following cycle; data 8A,15,2B,57 on four valid cycles; last on 57; then IDLE for one cycle; then next burst data AE,5C,...
REQ-034 req=4'b1111 held: grant order 0,1,2,3,0; each burst is 4 beats; one gap cycle between bursts; data continues without repeats.
REQ-035 In IDLE, seed_valid=1 with seed=8'h01, then req=4'b0010: data 01,03,07,0F; gnt=0010.
REQ-036 seed_valid=1 with seed=8'h00: the next burst starts at 8A.
REQ-037 req0 dropped after the 2nd beat (8A,15): FSM in IDLE next cycle; a new req2 burst starts at 2B; the following arbitration starts search at index 1.
REQ-038 reset asserted mid-burst, and seed_valid during BURST: gnt drops to 0 and the next burst restarts at 8A; a seed presented during BURST leaves the data sequence unchanged.

Source files
------------

// File: rtl/lfsr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_arbiter_pkg
//  Description : Shared constants, state encoding and LFSR step function for
//                the LFSR burst arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_arbiter_pkg;

    // LFSR state after reset and substitute for an all-zero seed
    localparam logic [7:0] c_DEFAULT_SEED = 8'h8A;

    // Feedback taps: bits 0, 3, 5 and 6
    localparam logic [7:0] c_LFSR_TAPS = 8'b0110_1001;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // One LFSR step: shift left, feedback from the XOR of the tapped bits
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & c_LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_core
//  Description : 8-bit LFSR register with synchronous reset, parallel load
//                (zero load replaced by the default seed) and advance enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_core
    import lfsr_arbiter_pkg::*;
#(
    parameter logic [7:0] DEFAULT_SEED = c_DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       advance,
    output logic [7:0] state
);

    // Load wins over advance; an all-zero load would lock the LFSR, so it is
    // replaced by the default seed
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DEFAULT_SEED;
        end else if (load) begin
            state <= (load_value == 8'h00) ? DEFAULT_SEED : load_value;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_arbiter
//  Description : Round-robin arbiter that grants NREQ requesters bursts of
//                BURST beats of pseudo-random LFSR data. Reseeding is
//                accepted only while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_arbiter
    import lfsr_arbiter_pkg::*;
#(
    parameter int         NREQ         = 4,
    parameter int         BURST        = 4,
    parameter logic [7:0] DEFAULT_SEED = c_DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [7:0]      data,
    output logic            valid,
    output logic            last,
    input  logic            seed_valid,
    input  logic [7:0]      seed,
    output logic            seed_ready
);

    localparam int c_IDX_W = $clog2(NREQ);
    localparam int c_CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(BURST - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(NREQ - 1);

    state_t               r_state,  w_state_nxt;
    logic [NREQ-1:0]      r_gnt,    w_gnt_nxt;
    logic [c_IDX_W-1:0]   r_owner,  w_owner_nxt;
    logic [c_CNT_W-1:0]   r_beat,   w_beat_nxt;
    logic [c_IDX_W-1:0]   r_ptr,    w_ptr_nxt;

    logic [c_IDX_W-1:0]   w_cand;
    logic [c_IDX_W-1:0]   w_pick;
    logic                 w_any;
    logic [c_IDX_W-1:0]   w_owner_inc;
    logic                 w_idle;
    logic                 w_valid;
    logic                 w_last;
    logic                 w_load;
    logic [7:0]           w_lfsr;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_valid     = (r_state == ST_BURST) && req[r_owner];
    assign w_last      = w_valid && (r_beat == c_LAST_BEAT);
    assign w_load      = w_idle && seed_valid;
    assign w_owner_inc = (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;

    assign gnt        = r_gnt;
    assign data       = w_lfsr;
    assign valid      = w_valid;
    assign last       = w_last;
    assign seed_ready = w_idle;

    lfsr_core #(
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_lfsr_core (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .load_value (seed),
        .advance    (w_valid),
        .state      (w_lfsr)
    );

    // Round-robin search: first requester at or after the pointer, wrapping
    always_comb begin
        w_cand = '0;
        w_pick = '0;
        w_any  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = c_IDX_W'((int'(r_ptr) + i) % NREQ);
            if (!w_any && req[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    // Next-state logic: seed beats arbitration in IDLE; a burst ends on its
    // final beat or when the owner withdraws, and either way the pointer
    // moves past the owner
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_beat_nxt  = r_beat;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (!seed_valid && w_any) begin
                    w_state_nxt       = ST_BURST;
                    w_gnt_nxt         = '0;
                    w_gnt_nxt[w_pick] = 1'b1;
                    w_owner_nxt       = w_pick;
                    w_beat_nxt        = '0;
                end
            end
            ST_BURST: begin
                if (!req[r_owner] || w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_owner_inc;
                end else begin
                    w_beat_nxt = r_beat + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State register; reset makes index 0 the highest priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_beat  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_beat  <= w_beat_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_arbiter
//  Description : Directed self-checking bench for lfsr_arbiter (NREQ=4,
//                BURST=4) with hand-computed LFSR sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       seed_valid;
    logic [7:0] seed;
    logic       seed_ready;

    int n_total = 0;
    int n_bad   = 0;

    lfsr_arbiter #(
        .NREQ         (4),
        .BURST        (4),
        .DEFAULT_SEED (8'h8A)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .gnt        (gnt),
        .data       (data),
        .valid      (valid),
        .last       (last),
        .seed_valid (seed_valid),
        .seed       (seed),
        .seed_ready (seed_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with the requester already driving: the next
    // edge grants, four beats follow, then one IDLE gap cycle is checked
    task automatic burst_expect(input string tag, input logic [3:0] g,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] d [4];
        d = '{d0, d1, d2, d3};
        tick();
        for (int b = 0; b < 4; b++) begin
            check({tag, "_gnt"},   32'(gnt),   32'(g));
            check({tag, "_valid"}, 32'(valid), 32'd1);
            check({tag, "_data"},  32'(data),  32'(d[b]));
            check({tag, "_last"},  32'(last),  (b == 3) ? 32'd1 : 32'd0);
            check({tag, "_rdy"},   32'(seed_ready), 32'd0);
            tick();
        end
        check({tag, "_gap_gnt"},   32'(gnt),        32'd0);
        check({tag, "_gap_valid"}, 32'(valid),      32'd0);
        check({tag, "_gap_rdy"},   32'(seed_ready), 32'd1);
    endtask

    task automatic do_reset(input string tag);
        reset      = 1'b1;
        req        = 4'b0000;
        seed_valid = 1'b0;
        seed       = 8'h00;
        tick();
        check({tag, "_gnt"},   32'(gnt),        32'd0);
        check({tag, "_valid"}, 32'(valid),      32'd0);
        check({tag, "_last"},  32'(last),       32'd0);
        check({tag, "_rdy"},   32'(seed_ready), 32'd1);
        check({tag, "_data"},  32'(data),       32'h8A);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req        = 4'b0000;
        seed_valid = 1'b0;
        seed       = 8'h00;

        // Single requester held: two bursts separated by one gap cycle
        do_reset("rst1");
        req = 4'b0001;
        #1;
        check("pre_grant_gnt", 32'(gnt), 32'd0);
        burst_expect("solo_b1", 4'b0001, 8'h8A, 8'h15, 8'h2B, 8'h57);
        burst_expect("solo_b2", 4'b0001, 8'hAE, 8'h5C, 8'hB8, 8'h70);
        req = 4'b0000;

        // All requesting: round-robin 0,1,2,3,0 with continuous data
        do_reset("rst2");
        req = 4'b1111;
        burst_expect("rr0", 4'b0001, 8'h8A, 8'h15, 8'h2B, 8'h57);
        burst_expect("rr1", 4'b0010, 8'hAE, 8'h5C, 8'hB8, 8'h70);
        burst_expect("rr2", 4'b0100, 8'hE0, 8'hC0, 8'h81, 8'h03);
        burst_expect("rr3", 4'b1000, 8'h07, 8'h0F, 8'h1E, 8'h3D);
        burst_expect("rr4", 4'b0001, 8'h7B, 8'hF6, 8'hEC, 8'hD9);
        req = 4'b0000;

        // Seed beats a simultaneous request, then the burst uses the seed
        do_reset("rst3");
        seed_valid = 1'b1;
        seed       = 8'h01;
        req        = 4'b0010;
        tick();
        check("seed_prio_gnt", 32'(gnt),        32'd0);
        check("seed_prio_rdy", 32'(seed_ready), 32'd1);
        seed_valid = 1'b0;
        burst_expect("seed01", 4'b0010, 8'h01, 8'h03, 8'h07, 8'h0F);
        req = 4'b0000;

        // Zero seed falls back to the default seed
        seed_valid = 1'b1;
        seed       = 8'h00;
        req        = 4'b0001;
        tick();
        check("seed00_gnt", 32'(gnt), 32'd0);
        seed_valid = 1'b0;
        burst_expect("seed00", 4'b0001, 8'h8A, 8'h15, 8'h2B, 8'h57);
        req = 4'b0000;

        // Owner withdraws after two beats: abort without advancing the LFSR
        do_reset("rst4");
        req = 4'b0001;
        tick();
        check("ab_b0_data", 32'(data), 32'h8A);
        tick();
        check("ab_b1_data", 32'(data), 32'h15);
        tick();
        req = 4'b0100;
        #1;
        check("ab_drop_valid", 32'(valid), 32'd0);
        check("ab_drop_last",  32'(last),  32'd0);
        tick();
        check("ab_idle_gnt", 32'(gnt),        32'd0);
        check("ab_idle_rdy", 32'(seed_ready), 32'd1);
        check("ab_idle_data", 32'(data),      32'h2B);
        // Search now starts at index 1, so requester 2 wins over requester 0
        req = 4'b0101;
        burst_expect("ab_r2", 4'b0100, 8'h2B, 8'h57, 8'hAE, 8'h5C);
        burst_expect("ab_r0", 4'b0001, 8'hB8, 8'h70, 8'hE0, 8'hC0);
        req = 4'b0000;

        // Seed during a burst is ignored; reset mid-burst restarts at 8A
        do_reset("rst5");
        req = 4'b0001;
        tick();
        check("mid_b0_data", 32'(data), 32'h8A);
        seed_valid = 1'b1;
        seed       = 8'h55;
        tick();
        check("mid_b1_data", 32'(data),       32'h15);
        check("mid_b1_rdy",  32'(seed_ready), 32'd0);
        tick();
        check("mid_b2_data", 32'(data), 32'h2B);
        check("mid_b2_gnt",  32'(gnt),  32'b0001);
        reset = 1'b1;
        tick();
        check("mid_rst_gnt",   32'(gnt),        32'd0);
        check("mid_rst_valid", 32'(valid),      32'd0);
        check("mid_rst_last",  32'(last),       32'd0);
        check("mid_rst_rdy",   32'(seed_ready), 32'd1);
        check("mid_rst_data",  32'(data),       32'h8A);
        reset      = 1'b0;
        seed_valid = 1'b0;
        burst_expect("mid_restart", 4'b0001, 8'h8A, 8'h15, 8'h2B, 8'h57);
        req = 4'b0000;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
